uart_tx: RTL
============

Name: uart_tx

Overview:
- 8N1 UART transmitter. It is the send-side counterpart of the team's uart_rx and shares its bit timing (CLKS_PER_BIT).
- A small byte FIFO with a valid/ready push handshake lets the accelerator queue results back-to-back.
- A `transmit` enable gates when new frames may start, mirroring the `receive` enable on the RX side.
- Serial output idles high and drives the FPGA TX pin directly.

Parameters:
- CLKS_PER_BIT, 10416: clocks per serial bit, equal to (i_Clock freq)/(baud). Must be ≥ 2.
- FIFO_DEPTH, 4: byte FIFO entries. Power of two, ≥ 2.

Ports:
- i_Clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on the i_Clock rising edge.
- transmit  in  1  1 = new frames may start. 0 = finish the current frame, then hold idle.
- i_Tx_DV  in  1  push request; byte accepted on an edge where i_Tx_DV=1 and o_Tx_Ready=1.
- i_Tx_Byte  in  8  byte to queue.
- o_Tx_Ready  out  1  FIFO not full.
- o_Tx_Serial  out  1  serial line, registered; idle = 1.
- o_Tx_Active  out  1  1 from the START state through the STOP state.
- o_Tx_Done  out  1  one-cycle pulse after each completed stop bit.
- o_Fifo_Count  out  $clog2(FIFO_DEPTH)+1  number of queued bytes, excluding the byte currently shifting.

Behaviour:
- Reset (reset=0 at an edge), taking effect at that edge:
  - FIFO emptied; o_Fifo_Count=0, o_Tx_Ready=1.
  - State → IDLE; o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0.
  - Clock counter and bit index = 0.
  - A frame in flight is aborted immediately and the line returns high.
- FIFO:
  - Push when i_Tx_DV & o_Tx_Ready.
  - Pop only when the FSM leaves IDLE.
  - Push and pop on the same edge leaves the count unchanged.
  - i_Tx_DV while full is ignored, with no overwrite.
  - Pointers wrap modulo FIFO_DEPTH.
- Clock counter: 18 bits; counts 0..CLKS_PER_BIT-1 in each bit state, then resets to 0.
- FSM states:
  - IDLE: o_Tx_Serial=1. If transmit=1 and count>0: pop the head into the shift register → START.
  - START: o_Tx_Serial=0 for CLKS_PER_BIT cycles → DATA, bit index 0.
  - DATA: o_Tx_Serial = shift[bit index], LSB first, each bit held CLKS_PER_BIT cycles. After bit 7 → PARITY if UART_TX_PARITY_EN, else → STOP.
  - PARITY (optional): even-parity bit, held CLKS_PER_BIT cycles → STOP.
  - STOP: o_Tx_Serial=1 for CLKS_PER_BIT cycles → IDLE, with o_Tx_Done=1 for exactly the first IDLE cycle.
  - Illegal state encoding → IDLE.
- Latency:
  - Byte pushed at edge N into an empty FIFO while in IDLE with transmit=1: pop at edge N+1, start bit visible after edge N+1.
  - Frame length is 10×CLKS_PER_BIT cycles (11× with parity).
  - Back-to-back frames are separated by exactly one idle-high clock.
- transmit: sampled only in IDLE. Dropping it mid-frame does not truncate the frame.
- i_Tx_Byte changes after acceptance do not affect the queued or shifting data.

Optional Feature:
- UART_TX_PARITY_EN defined:
  - PARITY state inserted after DATA.
  - Bit value = XOR of the 8 data bits (even parity).
  - Frame = 11 bits (8E1).
- Not defined:
  - No PARITY state or parity logic.
  - Frame = 10 bits (8N1).

Test Plan:
- Single byte, CLKS_PER_BIT=4, byte 0xA5, transmit=1:
  - Serial = 0, then 1,0,1,0,0,1,0,1, then 1; each bit exactly 4 clocks.
  - o_Tx_Active high 40 clocks; o_Tx_Done single pulse 1 clock after the stop bit ends.
- Burst fill, FIFO_DEPTH=4, transmit=0, push 0x01..0x05 on consecutive cycles:
  - First four accepted, o_Tx_Ready=0 after the 4th, 0x05 dropped, count=4.
  - Raise transmit: frames 0x01,0x02,0x03,0x04 in order, each separated by a 1-clock gap.
- Transmit gating: drop transmit in the middle of bit 3 with 2 bytes queued:
  - Current frame completes intact; line stays 1, count=2.
  - Re-raise transmit: next frame starts 1 clock later.
- Reset mid-frame: assert reset=0 during DATA bit 5:
  - Next edge: o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Fifo_Count=0, o_Tx_Ready=1.
  - No o_Tx_Done pulse for the aborted frame.
- Simultaneous push/pop: count=1, IDLE, transmit=1, push 0x3C on the pop edge:
  - Count stays 1; 0x3C sent as the next frame.
- UART_TX_PARITY_EN defined, bytes 0x07 then 0x03:
  - Parity bit = 1 for 0x07, 0 for 0x03.
  - Frame length 11×CLKS_PER_BIT.
- Loopback: uart_tx o_Tx_Serial → uart_rx i_Rx_Serial, both CLKS_PER_BIT=87, random 256 bytes (parity off):
  - Every o_Rx_Byte matches the transmitted byte in order.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with a small byte FIFO and a transmit enable.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module uart_tx #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          i_Clock,
    input  logic                          reset,
    input  logic                          transmit,
    input  logic                          i_Tx_DV,
    input  logic [7:0]                    i_Tx_Byte,
    output logic                          o_Tx_Ready,
    output logic                          o_Tx_Serial,
    output logic                          o_Tx_Active,
    output logic                          o_Tx_Done,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [17:0] LAST = 18'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t            r_state, w_state_next;
    logic [17:0]       r_clk_count, w_clk_next;
    logic [2:0]        r_bit_idx, w_bit_next;
    logic [7:0]        r_shift;
    logic              r_serial, w_serial_next;
    logic              r_done, w_done_next;
    logic              w_pop, w_push, w_bit_end;
    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
    logic [AW:0]       r_count;

    assign w_bit_end    = r_clk_count == LAST;
    assign o_Tx_Ready   = r_count != (AW+1)'(FIFO_DEPTH);
    assign w_push       = i_Tx_DV & o_Tx_Ready;
    assign o_Tx_Serial  = r_serial;
    assign o_Tx_Active  = r_state != IDLE;
    assign o_Tx_Done    = r_done;
    assign o_Fifo_Count = r_count;

    // Serial output is registered, so the next-state logic also computes the next line level.
    always_comb begin
        w_state_next  = r_state;
        w_clk_next    = w_bit_end ? '0 : r_clk_count + 18'd1;
        w_bit_next    = r_bit_idx;
        w_serial_next = r_serial;
        w_done_next   = 1'b0;
        w_pop         = 1'b0;
        case (r_state)
            IDLE: begin
                w_clk_next    = '0;
                w_serial_next = 1'b1;
                if (transmit && r_count != '0) begin
                    w_pop         = 1'b1;
                    w_state_next  = START;
                    w_serial_next = 1'b0;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_next  = DATA;
                    w_bit_next    = 3'd0;
                    w_serial_next = r_shift[0];
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_next  = PARITY;
                        w_serial_next = ^r_shift;
`else
                        w_state_next  = STOP;
                        w_serial_next = 1'b1;
`endif
                    end else begin
                        w_bit_next    = r_bit_idx + 3'd1;
                        w_serial_next = r_shift[r_bit_idx + 3'd1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (w_bit_end) begin
                    w_state_next  = STOP;
                    w_serial_next = 1'b1;
                end
            end
`endif
            STOP: begin
                if (w_bit_end) begin
                    w_state_next  = IDLE;
                    w_serial_next = 1'b1;
                    w_done_next   = 1'b1;
                end
            end
            default: begin
                w_state_next  = IDLE;
                w_clk_next    = '0;
                w_bit_next    = 3'd0;
                w_serial_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_clk_count <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_serial    <= 1'b1;
            r_done      <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
        end else begin
            r_state     <= w_state_next;
            r_clk_count <= w_clk_next;
            r_bit_idx   <= w_bit_next;
            r_serial    <= w_serial_next;
            r_done      <= w_done_next;
            if (w_pop) r_shift <= r_mem[r_rd_ptr];
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            r_count     <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge i_Clock) begin
        if (w_push) r_mem[r_wr_ptr] <= i_Tx_Byte;
    end
endmodule
